ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 flush  in  1  kill instruction currently in EX (branch redirect).
REQ-004 mem_stall  in  1  downstream MEM stage cannot accept; hold outputs.
REQ-005 in_valid  in  1  ID/EX presents a real instruction this cycle.
REQ-006 rs1_data_in  in  32  operand A from ID/EX.
REQ-007 rs2_data_in  in  32  operand B / store data from ID/EX.
REQ-008 immediate_in  in  32  immediate from ID/EX.
REQ-009 rd_addr_in  in  5  destination register.
REQ-010 reg_write_in  in  1  writeback enable.
REQ-011 mem_read_in  in  1  load.
REQ-012 mem_write_in  in  1  store.
REQ-013 alu_op_in  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL (shamt = B[4:0]), 111 MUL (low 32 bits).
REQ-014 wb_sel_in  in  2  writeback source select, passed through unchanged.
REQ-015 alu_src_in  in  1  1 = operand B is immediate_in, 0 = forwarded rs2.
REQ-016 fwd_a_sel  in  2  operand A source: 00 rs1_data_in, 01 fwd_mem_data, 10 fwd_wb_data, 11 rs1_data_in.
REQ-017 fwd_b_sel  in  2  rs2 source, same encoding as fwd_a_sel.
REQ-018 fwd_mem_data  in  32  result forwarded from MEM stage.
REQ-019 fwd_wb_data  in  32  result forwarded from WB stage.
REQ-020 ex_stall  out  1  combinational; upstream SHALL hold ID/EX (enable low) while high.
REQ-021 out_valid  out  1  registered; EX/MEM output holds a real instruction.
REQ-022 alu_result_out  out  32  registered ALU/MUL result.
REQ-023 store_data_out  out  32  registered forwarded rs2 (not immediate).
REQ-024 rd_addr_out  out  5  registered rd.
REQ-025 reg_write_out  out  1  registered.
REQ-026 mem_read_out  out  1  registered.
REQ-027 mem_write_out  out  1  registered.
REQ-028 wb_sel_out  out  2  registered.

Function
REQ-029 Arithmetic: all ops 32-bit modulo 2^32; SLT yields 1/0 zero-extended; MUL yields low 32 bits of unsigned 32x32 product (equal to signed low word).
REQ-030 Single-cycle ops: when accepted (in_valid, alu_op != 111, no mem_stall, no flush), all outputs load at the next edge; latency 1 cycle; ex_stall stays low.
REQ-031 Bubble: in_valid=0 with no mem_stall loads out_valid=0, reg_write/mem_read/mem_write=0, data fields 0.
REQ-032 FSM states IDLE, MUL_BUSY, MUL_DONE; reset state IDLE.
REQ-033 IDLE: in_valid and alu_op=111 -> ex_stall high, latch forwarded A and B and metadata, count=0, next MUL_BUSY; output register loads bubble.
REQ-034 MUL_BUSY: one shift-add iteration per edge (one multiplier bit); ex_stall high; after 32nd iteration (count=31) -> MUL_DONE; outputs load bubble each edge.
REQ-035 MUL_DONE: ex_stall low; next edge loads product and latched metadata with out_valid=1 -> IDLE; result visible 34 edges after MUL first presented.
REQ-036 mem_stall high: output register, FSM state, counter and accumulators all hold; ex_stall forced high.
REQ-037 flush high: FSM -> IDLE, MUL aborted; if mem_stall low, outputs load bubble; if mem_stall high, outputs hold (instruction in EX/MEM is older and not killed).
REQ-038 Priority per edge: rst_n > flush > mem_stall > FSM/normal operation.
REQ-039 Forwarding mux and operand B select are purely combinational from current inputs; MUL uses only values latched in IDLE.

Reset
REQ-040 rst_n low asynchronously forces IDLE, count=0, every registered output 0; ex_stall=0 while in reset; reset mid-MUL discards it.

Verification
REQ-041 ADD rs1=5, imm=7, alu_src=1, rd=3, reg_write=1 -> next edge alu_result_out=12, rd_addr_out=3, out_valid=1.
REQ-042 SUB with fwd_a_sel=01, fwd_mem_data=100, rs2=1 -> alu_result_out=99; SLT A=-1,B=1 -> 1; SLL A=1,B=0x21 -> 2.
REQ-043 MUL A=0xFFFFFFFF, B=3 -> ex_stall high 33 cycles, out_valid=1, alu_result_out=0xFFFFFFFD on edge 34.
REQ-044 flush at MUL_BUSY count=10 -> IDLE next edge, ex_stall low, out_valid=0, no result ever emitted.
REQ-045 mem_stall held 5 cycles with valid output -> outputs unchanged, ex_stall high; MUL in progress completes 5 cycles later.
REQ-046 rst_n low mid-MUL -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/ex_stage.sv
//==============================================================================
// Module      : ex_stage
// Description : Pipeline execute stage. Selects forwarded operands, runs a
//               single-cycle ALU (ADD/SUB/AND/OR/XOR/SLT/SLL) and a 32-cycle
//               iterative shift-add multiplier. The result is registered into
//               the EX/MEM output register.
// Ports       : clk, rst_n            - clock, asynchronous active-low reset
//               flush                 - kill the instruction currently in EX
//               mem_stall             - MEM cannot accept; hold everything
//               in_valid + *_in       - instruction fields from ID/EX
//               fwd_a_sel, fwd_b_sel  - operand source selects
//               fwd_mem_data/wb_data  - forwarded results
//               ex_stall              - combinational hold request to ID/EX
//               out_valid + *_out     - registered EX/MEM outputs
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        mem_stall,
    input  logic        in_valid,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] immediate_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  alu_op_in,
    input  logic [1:0]  wb_sel_in,
    input  logic        alu_src_in,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] fwd_mem_data,
    input  logic [31:0] fwd_wb_data,
    output logic        ex_stall,
    output logic        out_valid,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  rd_addr_out,
    output logic        reg_write_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [1:0]  wb_sel_out
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
    localparam logic [2:0] c_OP_SLL = 3'b110;
    localparam logic [2:0] c_OP_MUL = 3'b111;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] c_ST_MUL_DONE = 2'd2;

    localparam logic [4:0] c_LAST_ITER = 5'd31;

    // FSM and multiplier datapath
    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [31:0] r_mul_store;
    logic [4:0]  r_mul_rd;
    logic        r_mul_reg_write;
    logic        r_mul_mem_read;
    logic        r_mul_mem_write;
    logic [1:0]  r_mul_wb_sel;

    // EX/MEM output register
    logic        r_out_valid;
    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_rd_addr;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [1:0]  r_wb_sel;

    logic [31:0] w_op_a;
    logic [31:0] w_rs2_fwd;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;
    logic        w_is_mul;

    logic        w_nxt_valid;
    logic [31:0] w_nxt_alu_result;
    logic [31:0] w_nxt_store_data;
    logic [4:0]  w_nxt_rd_addr;
    logic        w_nxt_reg_write;
    logic        w_nxt_mem_read;
    logic        w_nxt_mem_write;
    logic [1:0]  w_nxt_wb_sel;

    //--------------------------------------------------------------------------
    // Operand forwarding and operand-B select
    //--------------------------------------------------------------------------
    always_comb begin
        w_op_a = rs1_data_in;
        case (fwd_a_sel)
            2'b01:   w_op_a = fwd_mem_data;
            2'b10:   w_op_a = fwd_wb_data;
            default: w_op_a = rs1_data_in;
        endcase
    end

    always_comb begin
        w_rs2_fwd = rs2_data_in;
        case (fwd_b_sel)
            2'b01:   w_rs2_fwd = fwd_mem_data;
            2'b10:   w_rs2_fwd = fwd_wb_data;
            default: w_rs2_fwd = rs2_data_in;
        endcase
    end

    assign w_op_b   = alu_src_in ? immediate_in : w_rs2_fwd;
    assign w_is_mul = (alu_op_in == c_OP_MUL);

    //--------------------------------------------------------------------------
    // Single-cycle ALU; MUL is handled by the iterative datapath below
    //--------------------------------------------------------------------------
    always_comb begin
        w_alu_result = '0;
        case (alu_op_in)
            c_OP_ADD: w_alu_result = w_op_a + w_op_b;
            c_OP_SUB: w_alu_result = w_op_a - w_op_b;
            c_OP_AND: w_alu_result = w_op_a & w_op_b;
            c_OP_OR:  w_alu_result = w_op_a | w_op_b;
            c_OP_XOR: w_alu_result = w_op_a ^ w_op_b;
            c_OP_SLT: w_alu_result = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
            c_OP_SLL: w_alu_result = w_op_a << w_op_b[4:0];
            default:  w_alu_result = '0;
        endcase
    end

    // Held by reset so a stuck-high mem_stall cannot leak out during reset.
    // A flushed MUL in IDLE is killed rather than started, so it does not stall.
    assign ex_stall = rst_n & (mem_stall
                             | (r_state == c_ST_MUL_BUSY)
                             | ((r_state == c_ST_IDLE) & in_valid & w_is_mul & ~flush));

    //--------------------------------------------------------------------------
    // FSM and shift-add multiplier
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_ST_IDLE;
            r_count         <= '0;
            r_mcand         <= '0;
            r_mplier        <= '0;
            r_acc           <= '0;
            r_mul_store     <= '0;
            r_mul_rd        <= '0;
            r_mul_reg_write <= 1'b0;
            r_mul_mem_read  <= 1'b0;
            r_mul_mem_write <= 1'b0;
            r_mul_wb_sel    <= '0;
        end else if (flush) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
        end else if (!mem_stall) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && w_is_mul) begin
                        r_mcand         <= w_op_a;
                        r_mplier        <= w_op_b;
                        r_acc           <= '0;
                        r_count         <= '0;
                        r_mul_store     <= w_rs2_fwd;
                        r_mul_rd        <= rd_addr_in;
                        r_mul_reg_write <= reg_write_in;
                        r_mul_mem_read  <= mem_read_in;
                        r_mul_mem_write <= mem_write_in;
                        r_mul_wb_sel    <= wb_sel_in;
                        r_state         <= c_ST_MUL_BUSY;
                    end
                end
                c_ST_MUL_BUSY: begin
                    // One multiplier bit per edge, LSB first; only the low
                    // word is kept, so the shifted multiplicand may drop bits.
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                    if (r_count == c_LAST_ITER) begin
                        r_state <= c_ST_MUL_DONE;
                    end
                end
                c_ST_MUL_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Next value of the output register; defaults describe a bubble
    //--------------------------------------------------------------------------
    always_comb begin
        w_nxt_valid      = 1'b0;
        w_nxt_alu_result = '0;
        w_nxt_store_data = '0;
        w_nxt_rd_addr    = '0;
        w_nxt_reg_write  = 1'b0;
        w_nxt_mem_read   = 1'b0;
        w_nxt_mem_write  = 1'b0;
        w_nxt_wb_sel     = '0;
        if (!flush) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid && !w_is_mul) begin
                        w_nxt_valid      = 1'b1;
                        w_nxt_alu_result = w_alu_result;
                        w_nxt_store_data = w_rs2_fwd;
                        w_nxt_rd_addr    = rd_addr_in;
                        w_nxt_reg_write  = reg_write_in;
                        w_nxt_mem_read   = mem_read_in;
                        w_nxt_mem_write  = mem_write_in;
                        w_nxt_wb_sel     = wb_sel_in;
                    end
                end
                c_ST_MUL_DONE: begin
                    w_nxt_valid      = 1'b1;
                    w_nxt_alu_result = r_acc;
                    w_nxt_store_data = r_mul_store;
                    w_nxt_rd_addr    = r_mul_rd;
                    w_nxt_reg_write  = r_mul_reg_write;
                    w_nxt_mem_read   = r_mul_mem_read;
                    w_nxt_mem_write  = r_mul_mem_write;
                    w_nxt_wb_sel     = r_mul_wb_sel;
                end
                default: begin
                end
            endcase
        end
    end

    // A flush never discards the older instruction already held in EX/MEM:
    // with mem_stall high the register simply holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_wb_sel     <= '0;
        end else if (!mem_stall) begin
            r_out_valid  <= w_nxt_valid;
            r_alu_result <= w_nxt_alu_result;
            r_store_data <= w_nxt_store_data;
            r_rd_addr    <= w_nxt_rd_addr;
            r_reg_write  <= w_nxt_reg_write;
            r_mem_read   <= w_nxt_mem_read;
            r_mem_write  <= w_nxt_mem_write;
            r_wb_sel     <= w_nxt_wb_sel;
        end
    end

    assign out_valid      = r_out_valid;
    assign alu_result_out = r_alu_result;
    assign store_data_out = r_store_data;
    assign rd_addr_out    = r_rd_addr;
    assign reg_write_out  = r_reg_write;
    assign mem_read_out   = r_mem_read;
    assign mem_write_out  = r_mem_write;
    assign wb_sel_out     = r_wb_sel;

endmodule

`default_nettype wire
